piso_serializer: RTL

- Parallel-in/serial-out front stage that feeds the gate-level d_ff shift-register chain.
- Accepts a WIDTH-bit word over a valid/ready handshake and drives it MSB-first, one bit per clk, onto a serial line that connects to the chain's first stage input.
- Optionally appends one even-parity bit per word.
- Provides framing strobes (ser_valid, done) for downstream capture logic.

---
 rtl/piso_serializer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out front stage: valid/ready word load, MSB-first serial output.
// Define PISO_SERIALIZER_PARITY_EN to append one even-parity bit per word.
module piso_serializer #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PISO_SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    // Holds only the bits not yet on ser_out; the MSB goes straight to the output flop.
    logic [WIDTH-2:0] shreg_q, shreg_d;
    logic             ser_out_q, ser_out_d;
    logic             ser_valid_q, ser_valid_d;
    logic             done_q, done_d;
    logic             accept;
    logic             mid_word;
`ifdef PISO_SERIALIZER_PARITY_EN
    logic             par_q, par_d;
`endif

    always_comb begin
        load_ready = 1'b0;
        case (state_q)
            IDLE:    load_ready = 1'b1;
`ifdef PISO_SERIALIZER_PARITY_EN
            SHIFT:   load_ready = 1'b0;
            PAR:     load_ready = 1'b1;
`else
            SHIFT:   load_ready = (cnt_q == LAST);
`endif
            default: load_ready = 1'b0;
        endcase
    end

    assign accept   = load_valid & load_ready;
    assign mid_word = (state_q == SHIFT) && (cnt_q != LAST);
    assign busy     = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            done_q      <= 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            done_q      <= done_d;
`ifdef PISO_SERIALIZER_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = SHIFT;
            end
            SHIFT: begin
                if (cnt_q == LAST) begin
`ifdef PISO_SERIALIZER_PARITY_EN
                    state_d = PAR;
`else
                    state_d = accept ? SHIFT : IDLE;
`endif
                end
            end
`ifdef PISO_SERIALIZER_PARITY_EN
            PAR: begin
                state_d = accept ? SHIFT : IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        ser_out_d   = 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
        par_d       = par_q;
`endif
        if (accept) begin
            shreg_d   = load_data[WIDTH-2:0];
            cnt_d     = '0;
            ser_out_d = load_data[WIDTH-1];
`ifdef PISO_SERIALIZER_PARITY_EN
            par_d     = load_data[WIDTH-1];
`endif
        end else if (mid_word) begin
            shreg_d   = shreg_q << 1;
            cnt_d     = cnt_q + CW'(1);
            ser_out_d = shreg_q[WIDTH-2];
`ifdef PISO_SERIALIZER_PARITY_EN
            par_d     = par_q ^ shreg_q[WIDTH-2];
`endif
        end else if (state_d == IDLE) begin
            cnt_d   = '0;
            shreg_d = '0;
`ifdef PISO_SERIALIZER_PARITY_EN
        end else if (state_d == PAR) begin
            ser_out_d = par_q;
`endif
        end

        ser_valid_d = (state_d != IDLE);
`ifdef PISO_SERIALIZER_PARITY_EN
        done_d      = (state_d == PAR);
`else
        done_d      = (state_d == SHIFT) && (cnt_d == LAST);
`endif
    end

    assign ser_out   = ser_out_q;
    assign ser_valid = ser_valid_q;
    assign done      = done_q;

endmodule
